// File: rtl/fir_pkg.sv
// Shared types for the fir_srg stream controller: filter op encodings,
// controller FSM states and the block-counter width helper.
package fir_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_LOAD = 2'b01,
    OP_RUN  = 2'b10,
    OP_READ = 2'b11
  } fir_op_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    RD_ISSUE,
    RD_WAIT,
    SEND
  } fir_ctrl_state_t;

  // A one-sample block still needs a one-bit counter.
  function automatic int cnt_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/fir_stream_ctrl.sv
// Stream front/back end for fir_srg: loads one block of samples, runs the
// filter, then streams the results out over valid/ready.
//
// state    | meaning
// IDLE     | waiting for the first sample of a block
// CLEAR    | one-cycle filter reset (memories and done)
// LOAD     | accepting samples, one filter write per handshake
// RUN      | filter computing, waiting for fir_done
// RD_ISSUE | present read address to the filter
// RD_WAIT  | capture filter read data into the output register
// SEND     | holding a result until the sink accepts it
module fir_stream_ctrl
  import fir_pkg::*;
#(
  parameter int signalLength = 1000,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              fir_reset,
  output logic [31:0]       fir_addr,
  output logic [DATA_W-1:0] fir_x,
  output logic [1:0]        fir_op,
  input  logic [DATA_W-1:0] fir_y,
  input  logic              fir_done,
  output logic              busy
);

  localparam int CW = cnt_w(signalLength);
  localparam logic [CW-1:0] LAST_IDX = CW'(signalLength - 1);

  fir_ctrl_state_t   state_q, state_d;
  logic [CW-1:0]     wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  fir_op_t           fir_op_q, fir_op_d;
  logic [31:0]       fir_addr_q, fir_addr_d;
  logic [DATA_W-1:0] fir_x_q, fir_x_d, m_data_q, m_data_d;
  logic              fir_reset_q, fir_reset_d;
  logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      fir_op_q    <= OP_IDLE;
      fir_addr_q  <= '0;
      fir_x_q     <= '0;
      fir_reset_q <= 1'b1;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      fir_op_q    <= fir_op_d;
      fir_addr_q  <= fir_addr_d;
      fir_x_q     <= fir_x_d;
      fir_reset_q <= fir_reset_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    fir_op_d   = OP_IDLE;
    fir_addr_d = fir_addr_q;
    fir_x_d    = fir_x_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    unique case (state_q)
      IDLE: if (s_valid) state_d = CLEAR;
      CLEAR: begin
        wcnt_d  = '0;
        state_d = LOAD;
      end
      LOAD: if (s_valid) begin
        fir_op_d   = OP_LOAD;
        fir_addr_d = 32'(wcnt_q);
        fir_x_d    = s_data;
        if (wcnt_q == LAST_IDX) state_d = RUN;
        else                    wcnt_d  = wcnt_q + CW'(1);
      end
      RUN: begin
        if (fir_done) begin
          rcnt_d  = '0;
          state_d = RD_ISSUE;
        end else begin
          fir_op_d = OP_RUN;
        end
      end
      RD_ISSUE: begin
        fir_op_d   = OP_READ;
        fir_addr_d = 32'(rcnt_q);
        state_d    = RD_WAIT;
      end
      // fir_y is valid here: the read op/address were registered last edge.
      RD_WAIT: begin
        m_data_d  = fir_y;
        m_valid_d = 1'b1;
        m_last_d  = (rcnt_q == LAST_IDX);
        state_d   = SEND;
      end
      SEND: if (m_ready) begin
        m_valid_d = 1'b0;
        if (m_last_q) begin
          state_d = IDLE;
        end else begin
          rcnt_d  = rcnt_q + CW'(1);
          state_d = RD_ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    fir_reset_d = (state_d == CLEAR);
    busy_d      = (state_d != IDLE);
  end

  assign s_ready   = (state_q == LOAD);
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign fir_reset = fir_reset_q;
  assign fir_addr  = fir_addr_q;
  assign fir_x     = fir_x_q;
  assign fir_op    = fir_op_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl against a small behavioural fir_srg
// (n=4, signalLength=8, four unit coefficients).
module tb_fir_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last;
  logic        fir_reset;
  logic [31:0] fir_addr, fir_x, fir_y;
  logic [1:0]  fir_op;
  logic        fir_done, busy;

  int vectors = 0;
  int miscompares = 0;

  fir_stream_ctrl #(.signalLength(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .fir_reset(fir_reset), .fir_addr(fir_addr), .fir_x(fir_x), .fir_op(fir_op),
    .fir_y(fir_y), .fir_done(fir_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Filter model: done after 41 RUN edges, combinational read of sum of last 4 samples.
  logic [31:0] mem [8];
  int          run_cnt;
  always @(posedge clk) begin
    if (fir_reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      run_cnt  <= 0;
      fir_done <= 1'b0;
    end else begin
      if (fir_op == 2'b01) mem[fir_addr[2:0]] <= fir_x;
      if (fir_op == 2'b10 && !fir_done) begin
        run_cnt <= run_cnt + 1;
        if (run_cnt == 40) fir_done <= 1'b1;
      end
    end
  end
  always_comb begin
    fir_y = '0;
    for (int j = 0; j < 4; j++)
      if (int'(fir_addr[2:0]) - j >= 0) fir_y = fir_y + mem[int'(fir_addr[2:0]) - j];
  end

  logic [31:0] blk_in [8];
  logic [31:0] res_data [$];
  logic        res_last [$];
  int          op10_cnt, rst_pulses, stab_err;
  logic [31:0] basic_exp [8] = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd14, 32'd18, 32'd22, 32'd26};

  // abort: 0 run to completion, 1 stop after 10 RUN cycles, 2 stop in SEND after 3 results
  task automatic run_block(input bit rand_s, input bit rand_m, input int abort, output bit timed_out);
    int idx = 0;
    logic prev_fr, prev_mv = 0, prev_mr = 0, prev_ml = 0;
    logic [31:0] prev_md = 0;
    timed_out = 1'b1;
    res_data.delete(); res_last.delete();
    op10_cnt = 0; rst_pulses = 0; stab_err = 0;
    prev_fr = fir_reset;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (fir_op == 2'b10) op10_cnt++;
      if (fir_reset && !prev_fr) rst_pulses++;
      prev_fr = fir_reset;
      if (prev_mv && !prev_mr && (!m_valid || m_data !== prev_md || m_last !== prev_ml)) stab_err++;
      if ((abort == 1 && op10_cnt == 10) || (abort == 2 && res_data.size() == 3 && m_valid) ||
          (abort == 0 && res_data.size() == 8 && !busy)) begin
        timed_out = 1'b0;
        break;
      end
      s_valid = (idx < 8) && (!rand_s || $urandom_range(0, 1) == 1);
      s_data  = (idx < 8) ? blk_in[idx] : 32'd0;
      m_ready = !rand_m || $urandom_range(0, 1) == 1;
      if (s_valid && s_ready) idx++;
      if (m_valid && m_ready) begin
        res_data.push_back(m_data);
        res_last.push_back(m_last);
      end
      prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data; prev_ml = m_last;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({fir_reset, fir_op, fir_addr, fir_x} !== {1'b1, 2'b00, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_fir: got rst=%b op=%b addr=%0d x=%0d, want rst=1 op=00 addr=0 x=0", fir_reset, fir_op, fir_addr, fir_x);
    end
    vectors++;
    if ({m_valid, m_data, m_last, busy, s_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_stream: got mv=%b md=%0d ml=%b busy=%b sr=%b, want all 0", m_valid, m_data, m_last, busy, s_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (fir_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: fir_reset got %b want 0", fir_reset);
    end
  endtask

  task automatic test_basic();
    bit to;
    for (int i = 0; i < 8; i++) blk_in[i] = 32'(i + 1);
    run_block(1'b0, 1'b0, 0, to);
    vectors++;
    if (to || res_data.size() != 8) begin
      miscompares++;
      $display("FAIL basic_count: got %0d results (timeout=%b) want 8", res_data.size(), to);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (res_data[i] !== basic_exp[i] || res_last[i] !== (i == 7)) begin
          miscompares++;
          $display("FAIL basic_res[%0d]: got %0d last=%b want %0d last=%b", i, res_data[i], res_last[i], basic_exp[i], i == 7);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy: got %b want 0", busy);
    end
    vectors++;
    if (op10_cnt != 42) begin
      miscompares++;
      $display("FAIL compute_len: RUN cycles got %0d want 42", op10_cnt);
    end
    vectors++;
    if (rst_pulses != 1) begin
      miscompares++;
      $display("FAIL fir_reset_pulses: got %0d want 1", rst_pulses);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    for (int i = 0; i < 8; i++) blk_in[i] = 32'(i + 1);
    run_block(1'b1, 1'b1, 0, to);
    vectors++;
    if (to || res_data.size() != 8) begin
      miscompares++;
      $display("FAIL bp_count: got %0d results (timeout=%b) want 8", res_data.size(), to);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (res_data[i] !== basic_exp[i] || res_last[i] !== (i == 7)) begin
          miscompares++;
          $display("FAIL bp_res[%0d]: got %0d last=%b want %0d last=%b", i, res_data[i], res_last[i], basic_exp[i], i == 7);
        end
      end
    end
    vectors++;
    if (stab_err != 0) begin
      miscompares++;
      $display("FAIL bp_stable: %0d output changes during stall, want 0", stab_err);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int i = 0; i < 8; i++) blk_in[i] = 32'(i + 1);
    run_block(1'b0, 1'b0, 0, to);
    for (int i = 0; i < 8; i++) blk_in[i] = 32'd0;
    run_block(1'b0, 1'b0, 0, to);
    vectors++;
    if (to || res_data.size() != 8) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results (timeout=%b) want 8", res_data.size(), to);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (res_data[i] !== 32'd0 || res_last[i] !== (i == 7)) begin
          miscompares++;
          $display("FAIL b2b_res[%0d]: got %0d last=%b want 0 last=%b", i, res_data[i], res_last[i], i == 7);
        end
      end
    end
    vectors++;
    if (op10_cnt != 42) begin
      miscompares++;
      $display("FAIL b2b_compute_len: RUN cycles got %0d want 42", op10_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    for (int i = 0; i < 8; i++) blk_in[i] = 32'(i + 1);
    run_block(1'b0, 1'b0, 1, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL midrun_reach: RUN phase not reached, timeout=%b want 0", to);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({fir_reset, fir_op, fir_addr, busy, m_valid, s_ready} !== {1'b1, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrun_async: got rst=%b op=%b addr=%0d busy=%b mv=%b sr=%b, want 1 00 0 0 0 0",
               fir_reset, fir_op, fir_addr, busy, m_valid, s_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_block(1'b0, 1'b0, 0, to);
    vectors++;
    if (to || res_data.size() != 8) begin
      miscompares++;
      $display("FAIL midrun_count: got %0d results (timeout=%b) want 8", res_data.size(), to);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (res_data[i] !== basic_exp[i] || res_last[i] !== (i == 7)) begin
          miscompares++;
          $display("FAIL midrun_res[%0d]: got %0d last=%b want %0d last=%b", i, res_data[i], res_last[i], basic_exp[i], i == 7);
        end
      end
    end
  endtask

  task automatic test_reset_mid_readback();
    bit to;
    int extra = 0;
    for (int i = 0; i < 8; i++) blk_in[i] = 32'(i + 1);
    run_block(1'b0, 1'b0, 2, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL midrd_reach: fourth result not presented, timeout=%b want 0", to);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({m_valid, m_last, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL midrd_async: got mv=%b ml=%b busy=%b want 0 0 0", m_valid, m_last, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_valid || busy) extra++;
    end
    m_ready = 1'b0;
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL midrd_quiet: %0d cycles with m_valid/busy after reset, want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_mid_readback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
